// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: synchronous valid/ready initiator for an asynchronous single-port RAM
// bus with a fixed setup / access / hold sequence. Revision 1.0
`default_nettype none

module ram_access_ctrl #(
  parameter int data_width  = 8,
  parameter int ram_depth   = 256,
  parameter int wait_cycles = 1,
  localparam int addr_width = (ram_depth > 1) ? $clog2(ram_depth) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [addr_width-1:0] req_addr,
  input  logic [data_width-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic                  rsp_error,
  output logic [data_width-1:0] rsp_rdata,
  output logic [addr_width-1:0] address,
  output logic                  write,
  output logic                  chip_select,
  inout  wire  [data_width-1:0] data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] wait_init = 4'(wait_cycles);

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  op_write;
  logic                  op_error;
  logic                  drive_en;
  logic [data_width-1:0] wdata_q;
  logic                  addr_oob;

  // Out-of-range addresses can only exist when the depth is not a power of two.
  generate
    if (ram_depth == (1 << addr_width)) begin : g_oob_none
      assign addr_oob = 1'b0;
    end else begin : g_oob_cmp
      localparam logic [addr_width:0] depth_lim = (addr_width + 1)'(ram_depth);
      assign addr_oob = ({1'b0, req_addr} >= depth_lim);
    end
  endgenerate

  assign data = drive_en ? wdata_q : {data_width{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_rdata   <= '0;
      address     <= '0;
      write       <= 1'b0;
      chip_select <= 1'b0;
      drive_en    <= 1'b0;
      wait_cnt    <= '0;
      op_write    <= 1'b0;
      op_error    <= 1'b0;
      wdata_q     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state       <= SETUP;
            req_ready   <= 1'b0;
            address     <= req_addr;
            op_write    <= req_write;
            op_error    <= addr_oob;
            wdata_q     <= req_wdata;
            chip_select <= !addr_oob;
            drive_en    <= req_write && !addr_oob;
            write       <= 1'b0;
          end
        end
        SETUP: begin
          state    <= ACCESS;
          wait_cnt <= wait_init;
          write    <= op_write && !op_error;
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state     <= HOLD;
            write     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= op_write;
            rsp_error <= op_error;
            // Reads sample the bus here; errored reads return zero, writes keep old data.
            if (!op_write) begin
              rsp_rdata <= op_error ? '0 : data;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        HOLD: begin
          state       <= IDLE;
          chip_select <= 1'b0;
          drive_en    <= 1'b0;
          req_ready   <= 1'b1;
          rsp_write   <= 1'b0;
          rsp_error   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
